shifter_seq: RTL and testbench
==============================

# shifter_seq

Parametrised sequential shift unit, the multi-mode successor to the single-step universal shift register. It accepts a command (mode, shift amount, parallel data) under a start/busy/done handshake, then performs logical, arithmetic or rotate shifts one bit per clock while streaming serial input in and exposing the shifted-out bit. It sits on the datapath wherever a multi-cycle shift, rotate or serial/parallel conversion is needed, and is driven by a controller FSM.

## Interface
- WIDTH, 16: register width in bits.
- CNT_BITS, 4: width of shift-amount and counter fields; must satisfy 2^CNT_BITS ≥ WIDTH.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- start  input  1  command request; sampled only when idle or done.
- mode  input  3  operation code, latched on accept.
- amt  input  CNT_BITS  shift count, latched on accept.
- D  input  WIDTH  parallel load data, sampled on the accept edge only.
- SR  input  1  serial fill bit for right logical shift; sampled live on every shift edge.
- SL  input  1  serial fill bit for left shift; sampled live on every shift edge.
- Q  output  WIDTH  register contents.
- SO  output  1  last bit shifted out.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.

## Operation
- Mode codes: 000 HOLD; 001 SRL (fill SR); 010 SLL (fill SL); 011 LOAD (Q←D); 100 SRA (fill Q[MSB]); 101 ROR; 110 ROL; 111 reserved, executes as HOLD.
- States: IDLE, RUN, DONE. State encoding is internal.
- Accept: start=1 in IDLE or DONE. start in RUN is ignored entirely (no queuing).
- On accept with HOLD, LOAD, reserved, or amt=0: Q updated at the accept edge (LOAD only), then go to DONE. SO is unchanged.
- On accept with a shift/rotate mode and amt=k>0: latch mode, set cnt←k, go to RUN. Q is not changed on the accept edge.
- RUN, each edge: one 1-bit step of the latched mode; cnt←cnt−1; on the edge where cnt goes 1→0, go to DONE.
- SO on each step: right ops take the old Q[0]; left ops take the old Q[WIDTH-1]. Rotates also drive SO.
- DONE: done=1 for exactly one cycle. The next edge goes to IDLE, or accepts a new command if start=1 (back-to-back).
- Reset (rst_n=0 at any edge, including mid-RUN): Q=0, SO=0, cnt=0, state IDLE, busy=0, done=0. An aborted operation never pulses done.

## Timing
- Reset values: Q=0, SO=0, busy=0, done=0.
- Shift with amt=k>0 accepted at edge E0: busy high after E0 through Ek; steps occur on E1..Ek; result valid and done=1 in the cycle after Ek. Latency is k+1 edges.
- Single-cycle ops (LOAD/HOLD/amt=0): result and done=1 in the cycle after E0.
- Throughput with back-to-back start in DONE: one command per k+1 cycles.
- busy and done are never high together.
- Q is stable whenever not in RUN, except on a LOAD accept edge.

## Structure
- Shared package shifter_pkg: mode code constants (MODE_HOLD … MODE_ROL), state encoding constants.
- One natural sub-module, shift_step: a combinational single-bit step taking (mode, Q, SR, SL) and returning (next Q, out bit). It is reusable by wider or multi-lane variants.
- Top holds the FSM, counter, latched mode, Q and SO registers.

## Test plan
All cases use WIDTH=16.
- LOAD D=0xA5C3: Q=0xA5C3 and done=1 the cycle after accept; busy never asserts.
- SRL amt=4, SR=0, from Q=0xA5C3: busy for 4 cycles, Q=0x0A5C, SO=0, done one cycle later.
- SRA amt=3 from 0x8010 → Q=0xF002. ROL amt=4 from 0x1234 → Q=0x2341. ROR amt=4 from 0x1234 → Q=0x4123.
- SLL amt=15, SL=1, from 0x0001 → Q=0xFFFF, SO=0. Also amt=0 with SRL → Q unchanged, done the next cycle.
- start pulsed mid-RUN with mode=LOAD, D=0x0000: ignored, original shift completes. start held high in DONE: new command accepted back-to-back.
- SRL amt=8 from 0xFFFF, rst_n low on the 3rd RUN edge: Q=0, SO=0, busy=0, and done never pulses.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared definitions for the sequential shifter: operation codes, FSM states
// and a helper classifying which operations run multi-cycle.
package shifter_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SRL  = 3'b001;
  localparam logic [2:0] MODE_SLL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_SRA  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ROL  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Shift and rotate codes need the RUN state; everything else finishes on accept.
  function automatic logic is_step_mode(input logic [2:0] m);
    logic r;
    case (m)
      MODE_SRL, MODE_SLL, MODE_SRA, MODE_ROR, MODE_ROL: r = 1'b1;
      default:                                          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step; returns the next register value
// and the bit that falls off the end.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] q,
  input  logic             sr,
  input  logic             sl,
  output logic [WIDTH-1:0] q_next,
  output logic             out_bit
);

  always_comb begin
    q_next  = q;
    out_bit = 1'b0;
    case (mode)
      MODE_SRL: begin
        q_next  = {sr, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      MODE_SLL: begin
        q_next  = {q[WIDTH-2:0], sl};
        out_bit = q[WIDTH-1];
      end
      MODE_SRA: begin
        q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      MODE_ROR: begin
        q_next  = {q[0], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      MODE_ROL: begin
        q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit = q[WIDTH-1];
      end
      default: begin
        q_next  = q;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shifter_seq.sv
// Sequential multi-mode shifter: accepts a command under start/busy/done and
// steps the latched shift or rotate one bit per clock.
module shifter_seq
  import shifter_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CNT_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          mode,
  input  logic [CNT_BITS-1:0] amt,
  input  logic [WIDTH-1:0]    D,
  input  logic                SR,
  input  logic                SL,
  output logic [WIDTH-1:0]    Q,
  output logic                SO,
  output logic                busy,
  output logic                done
);

  state_t              state_reg, state_next;
  logic [CNT_BITS-1:0] cnt_reg, cnt_next;
  logic [2:0]          mode_reg, mode_next;
  logic [WIDTH-1:0]    q_reg, q_next;
  logic                so_reg, so_next;
  logic [WIDTH-1:0]    step_q;
  logic                step_out;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .mode    (mode_reg),
    .q       (q_reg),
    .sr      (SR),
    .sl      (SL),
    .q_next  (step_q),
    .out_bit (step_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      mode_reg  <= MODE_HOLD;
      q_reg     <= '0;
      so_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
      q_reg     <= q_next;
      so_reg    <= so_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    q_next     = q_reg;
    so_next    = so_reg;
    case (state_reg)
      ST_RUN: begin
        // start is deliberately not looked at here: commands never queue.
        q_next   = step_q;
        so_next  = step_out;
        cnt_next = cnt_reg - CNT_BITS'(1);
        if (cnt_reg == CNT_BITS'(1)) state_next = ST_DONE;
      end
      default: begin
        if (start) begin
          if (is_step_mode(mode) && (amt != '0)) begin
            mode_next  = mode;
            cnt_next   = amt;
            state_next = ST_RUN;
          end else begin
            if (mode == MODE_LOAD) q_next = D;
            state_next = ST_DONE;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  assign Q    = q_reg;
  assign SO   = so_reg;
  assign busy = (state_reg == ST_RUN);
  assign done = (state_reg == ST_DONE);

endmodule

// File: tb/tb_shifter_seq.sv
// Directed bench for shifter_seq with a result scoreboard fed from an
// arithmetic reference model of each command.
module tb_shifter_seq;
  import shifter_pkg::*;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2:0]    mode;
  logic [3:0]    amt;
  logic [W-1:0]  D;
  logic          SR, SL;
  logic [W-1:0]  Q;
  logic          SO, busy, done;

  shifter_seq #(.WIDTH(W), .CNT_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .amt(amt), .D(D),
    .SR(SR), .SL(SL), .Q(Q), .SO(SO), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic         so;
    int           busy_cycles;
    string        tag;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] q_model  = '0;
  logic         so_model = 1'b0;
  int           pass_cnt  = 0;
  int           fail_cnt  = 0;
  int           total_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Whole-command reference written with wide shifts rather than bit steps.
  task automatic drive_cmd(input logic [2:0] m, input logic [3:0] k, input logic [W-1:0] d,
                           input string tag);
    exp_t                e;
    int                  n;
    logic [W-1:0]        ones;
    logic signed [W-1:0] sq;
    n    = int'(k);
    ones = '1;
    sq   = q_model;
    start = 1'b1; mode = m; amt = k; D = d;
    e.busy_cycles = (is_step_mode(m) && n > 0) ? n : 0;
    if (m == MODE_LOAD) q_model = d;
    else if (n > 0) begin
      case (m)
        MODE_SRL: begin so_model = q_model[n-1];   q_model = (q_model >> n) | (SR ? ~(ones >> n) : '0); end
        MODE_SLL: begin so_model = q_model[W-n];   q_model = (q_model << n) | (SL ? ~(ones << n) : '0); end
        MODE_SRA: begin so_model = q_model[n-1];   q_model = sq >>> n; end
        MODE_ROR: begin so_model = q_model[n-1];   q_model = (q_model >> n) | (q_model << (W - n)); end
        MODE_ROL: begin so_model = q_model[W-n];   q_model = (q_model << n) | (q_model >> (W - n)); end
        default: ;
      endcase
    end
    e.q = q_model; e.so = so_model; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [2:0] m, input logic [3:0] k, input logic [W-1:0] d,
                       input string tag);
    drive_cmd(m, k, d, tag);
    tick();
    start = 1'b0;
  endtask

  // Waits (bounded) for done, then pops and compares. inject >= 0 pulses a
  // LOAD of zero mid-run; chain holds start with the next command for back-to-back.
  task automatic wait_done(input int inject, input bit chain, input logic [2:0] nm,
                           input logic [3:0] na, input logic [W-1:0] nd, input string ntag);
    int   cyc;
    int   busy_cnt;
    bit   seen;
    exp_t e;
    cyc = 0; busy_cnt = 0; seen = 0;
    while (cyc < 40) begin
      if (done) begin seen = 1; break; end
      if (busy) busy_cnt++;
      if (chain) begin start = 1'b1; mode = nm; amt = na; D = nd; end
      else if (cyc == inject) begin start = 1'b1; mode = MODE_LOAD; amt = 4'd0; D = '0; end
      else start = 1'b0;
      tick();
      cyc++;
    end
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, "_done_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    check({e.tag, "_q"}, 32'(Q), 32'(e.q));
    check({e.tag, "_so"}, 32'(SO), 32'(e.so));
    check({e.tag, "_busy_cycles"}, busy_cnt, e.busy_cycles);
    check({e.tag, "_busy_in_done"}, 32'(busy), 32'd0);
    $display("txn %s: Q=0x%04h SO=%0b busy_cycles=%0d", e.tag, Q, SO, busy_cnt);
    if (chain) begin
      drive_cmd(nm, na, nd, ntag);
      tick();
      start = 1'b0;
    end else begin
      tick();
      check({e.tag, "_done_pulse"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = MODE_HOLD; amt = '0; D = '0; SR = 1'b0; SL = 1'b0;
    tick(); tick();
    check("rst_q", 32'(Q), 32'd0);
    check("rst_so", 32'(SO), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    issue(MODE_LOAD, 4'd0, 16'hA5C3, "load_a5c3");
    wait_done(-1, 0, MODE_HOLD, 4'd0, '0, "");
    SR = 1'b0;
    issue(MODE_SRL, 4'd4, '0, "srl4");
    wait_done(-1, 0, MODE_HOLD, 4'd0, '0, "");

    issue(MODE_LOAD, 4'd0, 16'h8010, "load_8010");
    wait_done(-1, 0, MODE_HOLD, 4'd0, '0, "");
    issue(MODE_SRA, 4'd3, '0, "sra3");
    wait_done(-1, 0, MODE_HOLD, 4'd0, '0, "");
    check("sra3_value", 32'(Q), 32'h0000F002);

    issue(MODE_LOAD, 4'd0, 16'h1234, "load_1234a");
    wait_done(-1, 0, MODE_HOLD, 4'd0, '0, "");
    issue(MODE_ROL, 4'd4, '0, "rol4");
    wait_done(-1, 0, MODE_HOLD, 4'd0, '0, "");
    issue(MODE_LOAD, 4'd0, 16'h1234, "load_1234b");
    wait_done(-1, 0, MODE_HOLD, 4'd0, '0, "");
    issue(MODE_ROR, 4'd4, '0, "ror4");
    wait_done(-1, 0, MODE_HOLD, 4'd0, '0, "");

    issue(MODE_LOAD, 4'd0, 16'h0001, "load_0001");
    wait_done(-1, 0, MODE_HOLD, 4'd0, '0, "");
    SL = 1'b1;
    issue(MODE_SLL, 4'd15, '0, "sll15");
    wait_done(-1, 0, MODE_HOLD, 4'd0, '0, "");
    SL = 1'b0;

    issue(MODE_SRL, 4'd0, 16'h1111, "srl0");
    wait_done(-1, 0, MODE_HOLD, 4'd0, '0, "");
    issue(MODE_HOLD, 4'd5, 16'h2222, "hold5");
    wait_done(-1, 0, MODE_HOLD, 4'd0, '0, "");
    issue(MODE_RSVD, 4'd3, 16'h3333, "rsvd3");
    wait_done(-1, 0, MODE_HOLD, 4'd0, '0, "");

    issue(MODE_LOAD, 4'd0, 16'h5A5A, "load_5a5a");
    wait_done(-1, 0, MODE_HOLD, 4'd0, '0, "");
    SR = 1'b1;
    issue(MODE_SRL, 4'd6, '0, "srl6_ignore_start");
    wait_done(2, 0, MODE_HOLD, 4'd0, '0, "");
    SR = 1'b0;

    issue(MODE_ROL, 4'd3, '0, "rol3_chain");
    wait_done(-1, 1, MODE_ROR, 4'd5, '0, "ror5_b2b");
    wait_done(-1, 0, MODE_HOLD, 4'd0, '0, "");

    // Abort an SRL by 8 with reset on its third RUN edge.
    issue(MODE_LOAD, 4'd0, 16'hFFFF, "load_ffff");
    wait_done(-1, 0, MODE_HOLD, 4'd0, '0, "");
    start = 1'b1; mode = MODE_SRL; amt = 4'd8;
    tick();
    start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q_model = '0; so_model = 1'b0;
    check("abort_q", 32'(Q), 32'd0);
    check("abort_so", 32'(SO), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    begin
      int done_hits;
      done_hits = 0;
      for (int i = 0; i < 12; i++) begin
        if (done || busy) done_hits++;
        tick();
      end
      check("abort_no_done", done_hits, 0);
    end
    $display("txn abort: Q=0x%04h SO=%0b busy=%0b", Q, SO, busy);

    issue(MODE_LOAD, 4'd0, 16'hC0DE, "load_after_abort");
    wait_done(-1, 0, MODE_HOLD, 4'd0, '0, "");
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
